// File: rtl/sram_tester_if.sv
// Transaction bus between the SRAM self-test master and sram_driver.
// The master issues one-cycle start requests; the slave answers with ready
// and, for reads, data that is valid once ready returns high.
interface sram_tester_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              mem_start;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_write;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data_read;

  modport master (
    output mem_start,
    output mem_re,
    output mem_address,
    output mem_data_write,
    input  mem_ready,
    input  mem_data_read
  );

  modport slave (
    input  mem_start,
    input  mem_re,
    input  mem_address,
    input  mem_data_write,
    output mem_ready,
    output mem_data_read
  );
endinterface

// File: rtl/sram_tester.sv
// SRAM built-in self-test master. Writes addr^seed to every location in
// 0..LAST_ADDR, reads everything back and reports a saturating mismatch
// count together with the first failing address and the data read there.
module sram_tester #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int LAST_ADDR = 8191,
  parameter int ERR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  sram_tester_if.master     mem
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_WAIT_LO,
    S_WR_WAIT_HI,
    S_RD_ISSUE,
    S_RD_WAIT_LO,
    S_RD_WAIT_HI,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] rdata_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ERR_W-1:0]  err_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;
  logic              start_q;
  logic              re_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] addr_ext;
  logic [DATA_W-1:0] expected_d;
  logic [ERR_W-1:0]  err_d;
  logic [ADDR_W-1:0] addr_inc_d;

  // Low address bits mapped onto the data width, zero-filled when the
  // address is narrower than the data word.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_addr_ext
    if (gi < ADDR_W) begin : g_bit
      assign addr_ext[gi] = addr_q[gi];
    end else begin : g_zero
      assign addr_ext[gi] = 1'b0;
    end
  end

  assign expected_d = addr_ext ^ seed_q;
  assign err_d      = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);
  assign addr_inc_d = addr_q + ADDR_W'(1);

  // Test sequencer: all outputs are registered here; mem_start defaults low
  // so it can only ever be a single-cycle pulse from an ISSUE state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      seed_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      start_q     <= 1'b0;
      re_q        <= 1'b0;
      maddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run) begin
            seed_q      <= seed;
            addr_q      <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            state_q     <= S_WR_ISSUE;
          end
        end
        S_WR_ISSUE: begin
          if (mem.mem_ready) begin
            start_q <= 1'b1;
            re_q    <= 1'b0;
            maddr_q <= addr_q;
            wdata_q <= expected_d;
            state_q <= S_WR_WAIT_LO;
          end
        end
        S_WR_WAIT_LO: begin
          if (!mem.mem_ready) state_q <= S_WR_WAIT_HI;
        end
        S_WR_WAIT_HI: begin
          if (mem.mem_ready) begin
            if (addr_q == LAST) begin
              addr_q  <= '0;
              state_q <= S_RD_ISSUE;
            end else begin
              addr_q  <= addr_inc_d;
              state_q <= S_WR_ISSUE;
            end
          end
        end
        S_RD_ISSUE: begin
          // Write data is left at its last value during reads.
          if (mem.mem_ready) begin
            start_q <= 1'b1;
            re_q    <= 1'b1;
            maddr_q <= addr_q;
            state_q <= S_RD_WAIT_LO;
          end
        end
        S_RD_WAIT_LO: begin
          if (!mem.mem_ready) state_q <= S_RD_WAIT_HI;
        end
        S_RD_WAIT_HI: begin
          if (mem.mem_ready) begin
            rdata_q <= mem.mem_data_read;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (rdata_q != expected_d) begin
            err_q <= err_d;
            if (err_q == '0) begin
              fail_addr_q <= addr_q;
              fail_data_q <= rdata_q;
            end
          end
          if (addr_q == LAST) begin
            state_q <= S_DONE;
          end else begin
            addr_q  <= addr_inc_d;
            state_q <= S_RD_ISSUE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_q == '0);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign error_count        = err_q;
  assign fail_addr          = fail_addr_q;
  assign fail_data          = fail_data_q;
  assign mem.mem_start      = start_q;
  assign mem.mem_re         = re_q;
  assign mem.mem_address    = maddr_q;
  assign mem.mem_data_write = wdata_q;

endmodule

// File: tb/tb_sram_tester.sv
// Bench for sram_tester: two testers (LAST_ADDR=15 and LAST_ADDR=0) each
// driving a behavioural sram_driver + SRAM model with optional faults.
// Expected bus transactions are queued when a run is started and compared
// as the tester issues them; final status is compared against a small model.
module tb_sram_tester;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 8;
  localparam int ERR_W     = 4;
  localparam int WAIT_TIME = 2;

  typedef struct packed {
    logic              k;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  logic mdl_rst;
  always #5 clk = ~clk;

  logic              run   [2];
  logic [DATA_W-1:0] seed  [2];
  logic              busy  [2];
  logic              done  [2];
  logic              pass  [2];
  logic [ERR_W-1:0]  err   [2];
  logic [ADDR_W-1:0] faddr [2];
  logic [DATA_W-1:0] fdata [2];
  logic              mstart[2];
  logic              mre   [2];
  logic [ADDR_W-1:0] maddr [2];
  logic [DATA_W-1:0] mwd   [2];
  logic              mready[2];
  logic [DATA_W-1:0] mrd   [2];

  int   n_checks = 0;
  int   n_fail   = 0;
  txn_t exp_q[$];
  int   fault_mode[2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LA = (gi == 0) ? 15 : 0;
    sram_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    sram_tester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(LA), .ERR_W(ERR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run[gi]),
      .seed       (seed[gi]),
      .busy       (busy[gi]),
      .done       (done[gi]),
      .pass       (pass[gi]),
      .error_count(err[gi]),
      .fail_addr  (faddr[gi]),
      .fail_data  (fdata[gi]),
      .mem        (bus.master)
    );
    assign mstart[gi]        = bus.mem_start;
    assign mre[gi]           = bus.mem_re;
    assign maddr[gi]         = bus.mem_address;
    assign mwd[gi]           = bus.mem_data_write;
    assign bus.mem_ready     = mready[gi];
    assign bus.mem_data_read = mrd[gi];
  end

  // Fault injection: 0 = clean, 1 = data bit 3 stuck at 0, 2 = inverted.
  function automatic logic [DATA_W-1:0] corrupt(int mode, logic [DATA_W-1:0] d);
    case (mode)
      1:       return d & 8'hF7;
      2:       return ~d;
      default: return d;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Behavioural sram_driver + SRAM: ready drops the cycle after a start,
  // stays low for WAIT_TIME+1 cycles, then the access completes.
  logic [DATA_W-1:0] mem_model [2][16];
  logic              drv_act [2];
  int                drv_cnt [2];
  logic              drv_re  [2];
  logic [3:0]        drv_addr[2];
  logic [DATA_W-1:0] drv_wd  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mdl_rst) begin
        mready[k]  <= 1'b1;
        mrd[k]     <= '0;
        drv_act[k] <= 1'b0;
        drv_cnt[k] <= 0;
      end else if (!drv_act[k]) begin
        if (mstart[k]) begin
          drv_act[k]  <= 1'b1;
          drv_cnt[k]  <= WAIT_TIME;
          mready[k]   <= 1'b0;
          drv_re[k]   <= mre[k];
          drv_addr[k] <= maddr[k][3:0];
          drv_wd[k]   <= mwd[k];
        end
      end else if (drv_cnt[k] != 0) begin
        drv_cnt[k] <= drv_cnt[k] - 1;
      end else begin
        drv_act[k] <= 1'b0;
        mready[k]  <= 1'b1;
        if (drv_re[k]) mrd[k] <= corrupt(fault_mode[k], mem_model[k][drv_addr[k]]);
        else           mem_model[k][drv_addr[k]] <= drv_wd[k];
      end
    end
  end

  // Bus monitor: pops the scoreboard on every start pulse.
  int   pulses[2]     = '{0, 0};
  int   done_edges[2] = '{0, 0};
  logic start_prev[2] = '{1'b0, 1'b0};
  logic done_prev[2]  = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mstart[k]) begin
        txn_t g;
        txn_t e;
        g.k    = k[0];
        g.re   = mre[k];
        g.addr = maddr[k];
        g.data = mre[k] ? '0 : mwd[k];
        $display("txn inst%0d %s addr=%0d wdata=0x%02h", k, mre[k] ? "RD" : "WR", maddr[k], mwd[k]);
        pulses[k] <= pulses[k] + 1;
        if (exp_q.size() == 0) begin
          check("unexpected_txn", 32'(g), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("txn", 32'(g), 32'(e));
        end
        if (start_prev[k]) check("start_back_to_back", 32'(1), 32'(0));
      end
      start_prev[k] <= mstart[k];
      if (done[k] && !done_prev[k]) done_edges[k] <= done_edges[k] + 1;
      done_prev[k] <= done[k];
    end
  end

  function automatic void model_result(int la, logic [DATA_W-1:0] s, int mode,
                                       output logic [ERR_W-1:0] e,
                                       output logic [ADDR_W-1:0] fa,
                                       output logic [DATA_W-1:0] fd);
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] r;
    e = '0; fa = '0; fd = '0;
    for (int a = 0; a <= la; a++) begin
      x = DATA_W'(a) ^ s;
      r = corrupt(mode, x);
      if (r != x) begin
        if (e == '0) begin
          fa = ADDR_W'(a);
          fd = r;
        end
        if (e != {ERR_W{1'b1}}) e = e + 1'b1;
      end
    end
  endfunction

  task automatic start_run(int k, int la, logic [DATA_W-1:0] s, int mode);
    txn_t t;
    fault_mode[k] = mode;
    for (int pass_no = 0; pass_no < 2; pass_no++) begin
      for (int a = 0; a <= la; a++) begin
        t.k    = k[0];
        t.re   = pass_no[0];
        t.addr = ADDR_W'(a);
        t.data = (pass_no == 0) ? (DATA_W'(a) ^ s) : '0;
        exp_q.push_back(t);
      end
    end
    seed[k] = s;
    run[k]  = 1'b1;
    @(negedge clk);
    run[k]  = 1'b0;
    seed[k] = ~s;   // must not affect the run already accepted
  endtask

  task automatic wait_done(int k);
    int guard = 0;
    while (!(done[k] && !busy[k]) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check("timeout_done", 32'(done[k]), 32'(1));
    @(negedge clk);
  endtask

  task automatic check_result(int k, int la, logic [DATA_W-1:0] s, int mode,
                              int pulse_base, int done_base);
    logic [ERR_W-1:0]  e;
    logic [ADDR_W-1:0] fa;
    logic [DATA_W-1:0] fd;
    model_result(la, s, mode, e, fa, fd);
    check("done",        32'(done[k]), 32'(1));
    check("busy",        32'(busy[k]), 32'(0));
    check("pass",        32'(pass[k]), 32'(e == '0));
    check("error_count", 32'(err[k]),  32'(e));
    check("fail_addr",   32'(faddr[k]), 32'(fa));
    check("fail_data",   32'(fdata[k]), 32'(fd));
    check("start_pulses", 32'(pulses[k] - pulse_base), 32'(2 * (la + 1)));
    check("done_edges",  32'(done_edges[k] - done_base), 32'(1));
    check("queue_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    int pb;
    int db;
    int guard;
    reset = 1'b1;
    mdl_rst = 1'b1;
    run  = '{1'b0, 1'b0};
    seed = '{8'h00, 8'h00};
    fault_mode = '{0, 0};
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_busy",   32'(busy[k]), 32'(0));
      check("rst_done",   32'(done[k]), 32'(0));
      check("rst_pass",   32'(pass[k]), 32'(0));
      check("rst_err",    32'(err[k]), 32'(0));
      check("rst_start",  32'(mstart[k]), 32'(0));
      check("rst_faddr",  32'(faddr[k]), 32'(0));
    end
    reset = 1'b0;
    mdl_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean memory, seed 0: data equals address.
    pb = pulses[0]; db = done_edges[0];
    start_run(0, 15, 8'h00, 0);
    wait_done(0);
    check_result(0, 15, 8'h00, 0, pb, db);

    // Data bit 3 stuck at 0 with seed 0xA5.
    pb = pulses[0]; db = done_edges[0];
    start_run(0, 15, 8'hA5, 1);
    wait_done(0);
    check_result(0, 15, 8'hA5, 1, pb, db);

    // Every read inverted: 16 mismatches saturate a 4-bit counter.
    pb = pulses[0]; db = done_edges[0];
    start_run(0, 15, 8'h3C, 2);
    wait_done(0);
    check_result(0, 15, 8'h3C, 2, pb, db);

    // Second run pulse during the read phase must be ignored.
    pb = pulses[0]; db = done_edges[0];
    start_run(0, 15, 8'h5A, 0);
    guard = 0;
    while (!(mstart[0] && mre[0] && maddr[0] == 13'd3) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) check("timeout_read3", 32'(0), 32'(1));
    run[0] = 1'b1;
    @(negedge clk);
    run[0] = 1'b0;
    wait_done(0);
    check_result(0, 15, 8'h5A, 0, pb, db);

    // Reset while waiting for the write of address 5 to complete.
    start_run(0, 15, 8'h42, 0);
    guard = 0;
    while (!(mstart[0] && !mre[0] && maddr[0] == 13'd5) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) check("timeout_write5", 32'(0), 32'(1));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy",  32'(busy[0]), 32'(0));
    check("midrst_done",  32'(done[0]), 32'(0));
    check("midrst_start", 32'(mstart[0]), 32'(0));
    check("midrst_err",   32'(err[0]), 32'(0));
    exp_q.delete();
    repeat (10) @(negedge clk);
    pb = pulses[0]; db = done_edges[0];
    start_run(0, 15, 8'h11, 0);
    wait_done(0);
    check_result(0, 15, 8'h11, 0, pb, db);

    // Single-location test.
    pb = pulses[1]; db = done_edges[1];
    start_run(1, 0, 8'hFF, 0);
    wait_done(1);
    check_result(1, 0, 8'hFF, 0, pb, db);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
